// File: rtl/gerenciador_entrada.sv
// -----------------------------------------------------------------------------
// gerenciador_entrada
//
// Input manager for the processor.
// The user sets a value on the board switches and commits it with a
// push-button. Each accepted button press stores one switch value in a small
// first-word fall-through FIFO.
//
// The processor pops one word per input instruction. If it reads while the
// FIFO is empty, the block raises 'espera', and the processor holds its PC
// until data arrives.
//
// Configuration macro:
//   GERENCIADOR_ENTRADA_SINAL_EN
//     Defined   : stored entries are sign-extended to 32 bits on dado_out.
//     Undefined : stored entries are zero-extended (default).
//
// Ports:
//   clk       in   system clock (same clock as PC / register file)
//   reset     in   synchronous, active-high reset
//   sw        in   [DATA_W-1:0] raw switch levels, asynchronous
//   btn       in   raw commit button, active-high, asynchronous, bouncy
//   rd_en     in   pop request, high during an input instruction
//   dado_out  out  [31:0] FIFO head word (0 while empty)
//   vazio     out  FIFO empty
//   cheio     out  FIFO full
//   espera    out  stall request (rd_en & vazio)
//   overflow  out  sticky: a commit was dropped because the FIFO was full
//   nivel     out  [$clog2(DEPTH):0] current occupancy
//
// Handshake:
//   A pop happens on a rising edge where rd_en=1 and vazio=0. The consumer
//   captures dado_out on that same edge. When rd_en=1 and vazio=1, espera=1
//   and nothing is consumed. The consumer keeps rd_en high until espera
//   drops.
// -----------------------------------------------------------------------------
module gerenciador_entrada #(
  parameter int DATA_W          = 8,
  parameter int DEPTH           = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        sw,
  input  logic                     btn,
  input  logic                     rd_en,
  output logic [31:0]              dado_out,
  output logic                     vazio,
  output logic                     cheio,
  output logic                     espera,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   nivel
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]      NIVEL_MAX = (AW+1)'(DEPTH);

  // Two-flop synchronizers for the asynchronous board inputs
  logic              r_btn_m, r_btn_s;
  logic [DATA_W-1:0] r_sw_m,  r_sw_s;

  // Debounce state
  logic [CNT_W-1:0]  r_cnt;
  logic              r_btn_acc;

  // FIFO state
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_nivel;
  logic              r_overflow;

  logic              w_flip;
  logic              w_push;
  logic              w_pop;
  logic              w_push_ok;
  logic              w_vazio;
  logic              w_cheio;
  logic [DATA_W-1:0] w_head;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_m <= 1'b0;
      r_btn_s <= 1'b0;
      r_sw_m  <= '0;
      r_sw_s  <= '0;
    end else begin
      r_btn_m <= btn;
      r_btn_s <= r_btn_m;
      r_sw_m  <= sw;
      r_sw_s  <= r_sw_m;
    end
  end

  // The accepted level flips on the edge where the counter would reach
  // DEBOUNCE_CYCLES. Only the rising flip commits a word, so one press
  // produces exactly one push.
  assign w_flip = (r_btn_s != r_btn_acc) && (r_cnt == CNT_LAST);
  assign w_push = w_flip && !r_btn_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_btn_acc <= 1'b0;
    end else if (r_btn_s == r_btn_acc) begin
      r_cnt <= '0;
    end else if (w_flip) begin
      r_cnt     <= '0;
      r_btn_acc <= ~r_btn_acc;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_vazio = (r_nivel == '0);
  assign w_cheio = (r_nivel == NIVEL_MAX);
  assign w_pop   = rd_en && !w_vazio;
  // A pop on the same edge frees the slot, so a push into a full FIFO
  // still fits.
  assign w_push_ok = w_push && (!w_cheio || w_pop);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= r_sw_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_nivel    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_nivel <= r_nivel + 1'b1;
        2'b01:   r_nivel <= r_nivel - 1'b1;
        default: r_nivel <= r_nivel;
      endcase
      if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    dado_out = '0;
    if (!w_vazio) begin
`ifdef GERENCIADOR_ENTRADA_SINAL_EN
      dado_out = {{(32-DATA_W){w_head[DATA_W-1]}}, w_head};
`else
      dado_out = {{(32-DATA_W){1'b0}}, w_head};
`endif
    end
  end

  assign vazio    = w_vazio;
  assign cheio    = w_cheio;
  assign espera   = rd_en && w_vazio;
  assign overflow = r_overflow;
  assign nivel    = r_nivel;

endmodule

// File: tb/tb_gerenciador_entrada.sv
// -----------------------------------------------------------------------------
// tb_gerenciador_entrada
//
// Directed bench for gerenciador_entrada with DATA_W=8, DEPTH=4 and
// DEBOUNCE_CYCLES=4.
//
// Inputs change 1 ns after a rising edge. Outputs are sampled at the same
// point, so "after edge N" means "after N calls to tick".
// -----------------------------------------------------------------------------
module tb_gerenciador_entrada;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int DEB    = 4;

`ifdef GERENCIADOR_ENTRADA_SINAL_EN
  localparam logic [31:0] EXP_F0 = 32'hFFFF_FFF0;
`else
  localparam logic [31:0] EXP_F0 = 32'h0000_00F0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] sw;
  logic              btn;
  logic              rd_en;
  logic [31:0]       dado_out;
  logic              vazio;
  logic              cheio;
  logic              espera;
  logic              overflow;
  logic [2:0]        nivel;

  int n_checks = 0;
  int n_errors = 0;

  gerenciador_entrada #(
    .DATA_W(DATA_W),
    .DEPTH(DEPTH),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw(sw),
    .btn(btn),
    .rd_en(rd_en),
    .dado_out(dado_out),
    .vazio(vazio),
    .cheio(cheio),
    .espera(espera),
    .overflow(overflow),
    .nivel(nivel)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // driver tasks
  // Full press + release: the push lands on the 6th edge, and the release
  // settles after 6 more edges.
  task automatic press(input logic [DATA_W-1:0] v);
    sw  = v;
    btn = 1'b1;
    repeat (6) tick();
    btn = 1'b0;
    repeat (6) tick();
  endtask

  task automatic pop_expect(input string name, input logic [31:0] exp);
    n_checks++;
    if (dado_out !== exp || vazio !== 1'b0) begin
      n_errors++;
      $display("FAIL %s: dado_out=%h vazio=%b expected dado_out=%h vazio=0", name, dado_out, vazio, exp);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    sw = '0; btn = 1'b0; rd_en = 1'b0;
    do_reset();
    n_checks++;
    if (vazio !== 1'b1 || cheio !== 1'b0 || nivel !== 3'd0 || overflow !== 1'b0 ||
        dado_out !== 32'h0 || espera !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: vazio=%b cheio=%b nivel=%0d ovf=%b dado=%h espera=%b expected 1 0 0 0 0 0",
               vazio, cheio, nivel, overflow, dado_out, espera);
    end
  endtask

  task automatic test_latency();
    sw  = 8'h2A;
    btn = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (vazio !== 1'b1) begin
      n_errors++;
      $display("FAIL latency_early: vazio=%b after edge 5 expected 1", vazio);
    end
    tick();
    n_checks++;
    if (vazio !== 1'b0 || nivel !== 3'd1 || dado_out !== 32'h0000_002A) begin
      n_errors++;
      $display("FAIL latency_push: vazio=%b nivel=%0d dado=%h expected 0 1 0000002a", vazio, nivel, dado_out);
    end
    repeat (10) tick();
    n_checks++;
    if (nivel !== 3'd1) begin
      n_errors++;
      $display("FAIL latency_hold: nivel=%0d expected 1", nivel);
    end
    btn = 1'b0;
    repeat (6) tick();
    pop_expect("latency_pop", 32'h2A);
    n_checks++;
    if (vazio !== 1'b1) begin
      n_errors++;
      $display("FAIL latency_empty: vazio=%b expected 1", vazio);
    end
  endtask

  // 3 high, 1 low, then steady high: the steady period starts at edge 6
  // (btn_s back high), and the push lands on edge 10.
  task automatic test_bounce();
    sw  = 8'h55;
    btn = 1'b1;
    repeat (3) tick();
    btn = 1'b0;
    tick();
    btn = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (vazio !== 1'b1) begin
      n_errors++;
      $display("FAIL bounce_early: vazio=%b after edge 9 expected 1", vazio);
    end
    tick();
    n_checks++;
    if (vazio !== 1'b0 || nivel !== 3'd1 || dado_out !== 32'h55) begin
      n_errors++;
      $display("FAIL bounce_push: vazio=%b nivel=%0d dado=%h expected 0 1 00000055", vazio, nivel, dado_out);
    end
    btn = 1'b0;
    repeat (6) tick();
    pop_expect("bounce_pop", 32'h55);
  endtask

  task automatic test_full_overflow();
    for (int k = 1; k <= 4; k++) press(DATA_W'(k));
    n_checks++;
    if (cheio !== 1'b1 || nivel !== 3'd4 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL full: cheio=%b nivel=%0d ovf=%b expected 1 4 0", cheio, nivel, overflow);
    end
    press(8'd5);
    n_checks++;
    if (cheio !== 1'b1 || nivel !== 3'd4 || overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL overflow: cheio=%b nivel=%0d ovf=%b expected 1 4 1", cheio, nivel, overflow);
    end
    for (int k = 1; k <= 4; k++) pop_expect("full_pop", 32'(k));
    n_checks++;
    if (vazio !== 1'b1 || overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL full_drain: vazio=%b ovf=%b expected 1 1", vazio, overflow);
    end
    do_reset();
    n_checks++;
    if (overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL overflow_clear: ovf=%b expected 0", overflow);
    end
  endtask

  task automatic test_stall();
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (espera !== 1'b1 || nivel !== 3'd0) begin
        n_errors++;
        $display("FAIL stall_idle: espera=%b nivel=%0d expected 1 0", espera, nivel);
      end
    end
    sw  = 8'h07;
    btn = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (espera !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_wait: espera=%b expected 1", espera);
    end
    tick();
    n_checks++;
    if (espera !== 1'b0 || dado_out !== 32'h7 || nivel !== 3'd1) begin
      n_errors++;
      $display("FAIL stall_land: espera=%b dado=%h nivel=%0d expected 0 00000007 1", espera, dado_out, nivel);
    end
    tick();
    n_checks++;
    if (vazio !== 1'b1 || espera !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_pop: vazio=%b espera=%b expected 1 1", vazio, espera);
    end
    rd_en = 1'b0;
    btn   = 1'b0;
    repeat (6) tick();
  endtask

  // Full FIFO, with a pop and a commit on the same edge: the commit fits.
  task automatic test_back_to_back();
    for (int k = 1; k <= 4; k++) press(DATA_W'(k));
    sw  = 8'd9;
    btn = 1'b1;
    repeat (5) tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (nivel !== 3'd4 || overflow !== 1'b0 || cheio !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_level: nivel=%0d ovf=%b cheio=%b expected 4 0 1", nivel, overflow, cheio);
    end
    btn = 1'b0;
    repeat (6) tick();
    pop_expect("b2b_pop2", 32'd2);
    pop_expect("b2b_pop3", 32'd3);
    pop_expect("b2b_pop4", 32'd4);
    pop_expect("b2b_pop9", 32'd9);
    n_checks++;
    if (vazio !== 1'b1 || nivel !== 3'd0) begin
      n_errors++;
      $display("FAIL b2b_empty: vazio=%b nivel=%0d expected 1 0", vazio, nivel);
    end
  endtask

  // A reset in the middle of a debounce restarts the full latency.
  task automatic test_reset_mid();
    sw  = 8'h3C;
    btn = 1'b1;
    repeat (4) tick();
    do_reset();
    repeat (5) tick();
    n_checks++;
    if (vazio !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_early: vazio=%b expected 1", vazio);
    end
    tick();
    n_checks++;
    if (vazio !== 1'b0 || dado_out !== 32'h3C) begin
      n_errors++;
      $display("FAIL reset_mid_push: vazio=%b dado=%h expected 0 0000003c", vazio, dado_out);
    end
    btn = 1'b0;
    repeat (6) tick();
    pop_expect("reset_mid_pop", 32'h3C);
  endtask

  task automatic test_sign();
    press(8'hF0);
    pop_expect("sign_ext", EXP_F0);
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_latency();
    test_bounce();
    test_full_overflow();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_sign();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
